// File: rtl/leg4_pkg.sv
// rtl/leg4_pkg.sv - shared opcode, subcode and sequencer state definitions
// Purpose: OPR codes, F_/E_ subop codes and the sequencer state encoding,
//          shared by the sequencer and the ALU.
// Ports:   none (package).
package leg4_pkg;

   typedef enum logic [3:0] {
      OPR_NOP = 4'h0, OPR_JCN = 4'h1, OPR_FIM = 4'h2, OPR_FIN = 4'h3,
      OPR_JUN = 4'h4, OPR_JMS = 4'h5, OPR_INC = 4'h6, OPR_ISZ = 4'h7,
      OPR_ADD = 4'h8, OPR_SUB = 4'h9, OPR_LD  = 4'hA, OPR_XCH = 4'hB,
      OPR_BBL = 4'hC, OPR_LDM = 4'hD, OPR_E   = 4'hE, OPR_F   = 4'hF
   } opr_e;

   typedef enum logic [3:0] {
      F_CLB = 4'h0, F_CLC = 4'h1, F_IAC = 4'h2, F_CMC = 4'h3,
      F_CMA = 4'h4, F_RAL = 4'h5, F_RAR = 4'h6, F_TCC = 4'h7,
      F_DAC = 4'h8, F_TCS = 4'h9, F_STC = 4'hA, F_DAA = 4'hB,
      F_KBP = 4'hC, F_DCL = 4'hD, F_RSV_E = 4'hE, F_RSV_F = 4'hF
   } f_sub_e;

   typedef enum logic [3:0] {
      E_WRM = 4'h0, E_WMP = 4'h1, E_WRR = 4'h2, E_WPM = 4'h3,
      E_WR0 = 4'h4, E_WR1 = 4'h5, E_WR2 = 4'h6, E_WR3 = 4'h7,
      E_SBM = 4'h8, E_RDM = 4'h9, E_RDR = 4'hA, E_ADM = 4'hB,
      E_RD0 = 4'hC, E_RD1 = 4'hD, E_RD2 = 4'hE, E_RD3 = 4'hF
   } e_sub_e;

   typedef enum logic [1:0] {
      S_FETCH1 = 2'd0,
      S_FETCH2 = 2'd1,
      S_EXEC   = 2'd2
   } state_e;

   // Instructions that carry a second program byte (FIM only when OPA[0]=0;
   // OPA[0]=1 in the same OPR is SRC, a single-byte instruction).
   function automatic logic is_two_byte(input logic [7:0] b);
      opr_e o;
      o = opr_e'(b[7:4]);
      return (o == OPR_JCN) || (o == OPR_JUN) || (o == OPR_JMS) ||
             (o == OPR_ISZ) || ((o == OPR_FIM) && !b[0]);
   endfunction

endpackage

// File: rtl/call_stack.sv
// rtl/call_stack.sv - three-deep circular return-address stack
// Purpose: 3 x 12-bit return stack. A push advances the pointer (mod 3) and
//          writes there, so a 4th push overwrites the oldest entry. A pop
//          returns the entry at the current pointer and steps it back, with
//          no empty/underflow tracking.
// Ports:   clk, rst_n      - clock, asynchronous active-low reset
//          push, pop       - one-cycle strobes (push wins if both are set)
//          push_data[11:0] - address to store
//          pop_data[11:0]  - entry at the current pointer
module call_stack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic [11:0] push_data,
   output logic [11:0] pop_data
);

   logic [1:0]  ptr_q, ptr_d;
   logic [11:0] stk_q [3];
   logic [11:0] stk_d [3];

   function automatic logic [1:0] wrap_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [1:0] wrap_dec(input logic [1:0] p);
      return (p == 2'd0) ? 2'd2 : p - 2'd1;
   endfunction

   always_comb begin
      ptr_d = ptr_q;
      stk_d = stk_q;
      if (push) begin
         ptr_d        = wrap_inc(ptr_q);
         stk_d[ptr_d] = push_data;
      end else if (pop) begin
         ptr_d = wrap_dec(ptr_q);
      end
   end

   assign pop_data = stk_q[ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 2'd0;
         for (int i = 0; i < 3; i++) stk_q[i] <= 12'h000;
      end else begin
         ptr_q <= ptr_d;
         stk_q <= stk_d;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute sequencer for the 4-bit core
// Purpose: fetches one or two program bytes, executes for one cycle, owns
//          PC, accumulator, carry and the return stack.
// Ports:   clk, rst_n                 - clock, asynchronous active-low reset
//          rom_addr/req/ack/data      - program byte fetch handshake
//          alu_op/sub_op/opa          - operation presented to the ALU
//          alu_result/carry/zero      - combinational ALU outputs
//          reg_addr/rdata/we/wdata    - index register file access
//          acc, carry                 - architectural accumulator and carry
//          hold                       - stall; freezes everything
//          instr_done                 - one-cycle pulse at retire
module instr_sequencer
   import leg4_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [11:0] rom_addr,
   output logic        rom_req,
   input  logic        rom_ack,
   input  logic [7:0]  rom_data,
   output logic [3:0]  alu_op,
   output logic [3:0]  alu_sub_op,
   output logic [3:0]  alu_opa,
   input  logic [3:0]  alu_result,
   input  logic        alu_carry,
   input  logic        alu_zero,
   output logic [3:0]  reg_addr,
   input  logic [3:0]  reg_rdata,
   output logic        reg_we,
   output logic [3:0]  reg_wdata,
   output logic [3:0]  acc,
   output logic        carry,
   input  logic        hold,
   output logic        instr_done
);

   state_e      state_q, state_d;
   logic [11:0] pc_q, pc_d;
   logic [7:0]  ir_q, ir_d;
   logic [7:0]  ir2_q, ir2_d;
   logic [3:0]  acc_q, acc_d;
   logic        carry_q, carry_d;
   logic        stk_push, stk_pop;
   logic [11:0] stk_rdata;
   opr_e        opr;
   logic [3:0]  opa;
   logic        jcn_cond;
   logic [3:0]  isz_val;
   logic        in_exec;
   logic        unused_alu_zero;

   assign opr      = opr_e'(ir_q[7:4]);
   assign opa      = ir_q[3:0];
   assign in_exec  = (state_q == S_EXEC);
   // Branch conditions look at acc directly, never at the ALU zero flag.
   assign jcn_cond = (opa[2] && (acc_q == 4'h0)) || (opa[1] && carry_q);
   assign isz_val  = reg_rdata + 4'd1;
   assign unused_alu_zero = alu_zero;

   assign rom_addr   = pc_q;
   assign rom_req    = !hold && ((state_q == S_FETCH1) || (state_q == S_FETCH2));
   assign alu_op     = in_exec ? ir_q[7:4] : 4'h0;
   assign alu_sub_op = in_exec ? opa : 4'h0;
   assign alu_opa    = ((opr == OPR_LDM) || (opr == OPR_BBL)) ? opa : reg_rdata;
   assign reg_addr   = opa;
   assign acc        = acc_q;
   assign carry      = carry_q;

   call_stack u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (pc_q),
      .pop_data  (stk_rdata)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir2_d      = ir2_q;
      acc_d      = acc_q;
      carry_d    = carry_q;
      reg_we     = 1'b0;
      reg_wdata  = 4'h0;
      instr_done = 1'b0;
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
      if (!hold) begin
         case (state_q)
            S_FETCH1: if (rom_ack) begin
               ir_d    = rom_data;
               pc_d    = pc_q + 12'd1;
               state_d = is_two_byte(rom_data) ? S_FETCH2 : S_EXEC;
            end
            S_FETCH2: if (rom_ack) begin
               ir2_d   = rom_data;
               pc_d    = pc_q + 12'd1;
               state_d = S_EXEC;
            end
            S_EXEC: begin
               instr_done = 1'b1;
               state_d    = S_FETCH1;
               // pc_q already points past the second byte here, so its page
               // is the one short jumps stay in and the JMS return address.
               case (opr)
                  OPR_JCN: if (jcn_cond ^ opa[3]) pc_d = {pc_q[11:8], ir2_q};
                  OPR_JUN: pc_d = {opa, ir2_q};
                  OPR_JMS: begin
                     stk_push = 1'b1;
                     pc_d     = {opa, ir2_q};
                  end
                  OPR_INC: begin
                     reg_we    = 1'b1;
                     reg_wdata = alu_result;
                  end
                  OPR_ISZ: begin
                     reg_we    = 1'b1;
                     reg_wdata = isz_val;
                     if (isz_val != 4'h0) pc_d = {pc_q[11:8], ir2_q};
                  end
                  OPR_ADD, OPR_SUB, OPR_LD, OPR_LDM: begin
                     acc_d   = alu_result;
                     carry_d = alu_carry;
                  end
                  OPR_F: if (f_sub_e'(opa) == F_CLB) begin
                     acc_d   = alu_result;
                     carry_d = alu_carry;
                  end
                  OPR_XCH: begin
                     reg_we    = 1'b1;
                     reg_wdata = acc_q;
                     acc_d     = reg_rdata;
                  end
                  OPR_BBL: begin
                     stk_pop = 1'b1;
                     pc_d    = stk_rdata;
                     acc_d   = alu_result;
                  end
                  default: ;
               endcase
            end
            default: state_d = S_FETCH1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH1;
         pc_q    <= 12'h000;
         ir_q    <= 8'h00;
         ir2_q   <= 8'h00;
         acc_q   <= 4'h0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ir2_q   <= ir2_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
      end
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 rom_addr  output  12  program byte address (current PC).
REQ-004 rom_req  output  1  high while a program byte is wanted.
REQ-005 rom_ack  input  1  rom_data valid this cycle; byte consumed on rising edge when rom_req && rom_ack.
REQ-006 rom_data  input  8  program byte, OPR in [7:4], OPA in [3:0].
REQ-007 alu_op / alu_sub_op  output  4 / 4  OPR and OPA of the executing instruction; both 4'h0 outside EXEC.
REQ-008 alu_opa  output  4  instruction OPA for LDM/BBL, reg_rdata otherwise.
REQ-009 alu_result, alu_carry, alu_zero  input  4,1,1  combinational ALU outputs.
REQ-010 reg_addr  output  4  index register = instruction OPA.
REQ-011 reg_rdata  input  4  combinational index register read.
REQ-012 reg_we  output  1  one-cycle register write strobe; reg_wdata  output  4.
REQ-013 acc, carry  output  4, 1  architectural accumulator and carry, registered here.
REQ-014 hold  input  1  stall request; instr_done  output  1  one-cycle pulse at each instruction retire.

Function
REQ-015 States FETCH1, FETCH2, EXEC; rom_req = 1 in FETCH1/FETCH2 only.
REQ-016 FETCH1: on consume, latch byte into IR, PC <= PC+1 (12-bit wrap FFF->000), go FETCH2 if OPR in {JCN, FIM(OPA[0]=0), JUN, JMS, ISZ}, else EXEC.
REQ-017 FETCH2: on consume, latch byte into IR2, PC <= PC+1 with wrap, go EXEC.
REQ-018 Zero wait states: 1-byte instruction = 2 cycles, 2-byte = 3 cycles.
REQ-019 EXEC lasts exactly one cycle, pulses instr_done, returns to FETCH1.
REQ-020 ADD, SUB, LD, LDM, F_/CLB: acc <= alu_result, carry <= alu_carry at end of EXEC.
REQ-021 INC: reg_we = 1, reg_wdata = alu_result; acc and carry unchanged.
REQ-022 XCH: reg_we = 1, reg_wdata = acc; acc <= reg_rdata, same edge.
REQ-023 JUN: PC <= {IR[3:0], IR2}.
REQ-024 JMS: push incremented PC (address after second byte) to stack, PC <= {IR[3:0], IR2}.
REQ-025 BBL: PC <= pop, acc <= alu_result (OPA), carry unchanged.
REQ-026 JCN: cond = (IR[2] && acc==0) || (IR[1] && carry); jump if cond XOR IR[3]; target {PC[11:8], IR2}, PC[11:8] taken after second-byte increment.
REQ-027 ISZ: reg_we = 1, reg_wdata = reg_rdata+1 (4-bit wrap); jump as JCN target when the written value is not 0.
REQ-028 Stack 3 x 12-bit, circular: 4th push overwrites oldest; pop on empty returns the entry at the current pointer, no error.
REQ-029 NOP, FIM, SRC, FIN, JIN, E_ group, other F_ subops: no architectural write beyond PC advance.
REQ-030 hold = 1 freezes all state, PC, acc, carry, and stack; forces rom_req, reg_we, and instr_done to 0; a pending rom_ack is ignored.
REQ-031 alu_zero is unused for control; JCN tests acc directly.

Reset
REQ-032 rst_n low asynchronously forces state FETCH1, PC 0, IR/IR2 0, acc 0, carry 0, stack pointer 0, all stack entries 0, reg_we 0, instr_done 0.
REQ-033 Reset mid-instruction abandons it; no partial write occurs after deassertion.
REQ-034 First rom_req is asserted in the cycle after rst_n rises, with rom_addr = 0.

Structure
REQ-035 OPR codes, F_/E_ subcodes, and state encoding live in shared package leg4_pkg, also used by alu.
REQ-036 The return stack is sub-module call_stack (push, pop, 12-bit data, 2-bit pointer).

Verification
REQ-037 Reset mid-EXEC: acc, carry, and PC read 0; next fetch is from address 0.
REQ-038 Program LDM 5; ADD r0 with r0=3, carry=0: after 4 cycles acc=8, carry=0; instr_done pulses twice.
REQ-039 JUN 0x123 at addr 0: next rom_addr is 0x123; a 1-cycle rom_ack delay on byte 2 extends the instruction by exactly 1 cycle.
REQ-040 JMS x4 then BBL x4 with OPA=7: returns follow the circular rule; the last BBL returns to the overwritten slot value; acc=7.
REQ-041 ISZ with r2=F: reg_wdata=0, no jump, PC=+2; with r2=3: reg_wdata=4, jump taken.
REQ-042 Hold asserted during FETCH2 for 3 cycles with rom_ack high: no state change; resumes identically after release.
